// File: rtl/tl_lrsc_monitor.sv
// tl_lrsc_monitor
// ---------------------------------------------------------------------------
// TileLink-UL stage that sits directly in front of a RAM slave and adds
// LR/SC reservation semantics. a_corrupt=1 on a Get marks a load-reserved.
// a_corrupt=1 on a PutFull/PutPartial marks a store-conditional.
// Failed SCs are answered locally and never reach the RAM. A successful SC is
// forwarded as a plain Put, and its response data is replaced with 0.
// Only one transaction is outstanding at a time. Every RAM D beat is captured
// and held until upstream takes it, so a single-cycle d_valid pulse is safe.
//
// Handshake rule on every channel: a beat transfers on a rising clk edge
// where valid && ready. Once a source raises valid, it holds valid and the
// payload stable until that edge. This block never makes its valid depend on
// the other side's ready.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   up_a_* / up_d_*     : slave side, from the core or crossbar
//   down_a_* / down_d_* : master side, to the RAM
//   resv_valid          : reservation is live (debug)
//   resv_addr           : reserved granule, a_address[63:GRANULE_LSB] (debug)
//   fsm_state           : current FSM state (debug)
//                         0 idle, 1 req, 2 wait, 3 rsp
// ---------------------------------------------------------------------------
module tl_lrsc_monitor #(
  parameter int RESV_TIMEOUT = 1024,
  parameter int GRANULE_LSB  = 3,
  parameter int SOURCE_W     = 8,
  parameter int SIZE_W       = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   up_a_valid,
  output logic                   up_a_ready,
  input  logic [2:0]             up_a_opcode,
  input  logic [2:0]             up_a_param,
  input  logic [SIZE_W-1:0]      up_a_size,
  input  logic [SOURCE_W-1:0]    up_a_source,
  input  logic [63:0]            up_a_address,
  input  logic [7:0]             up_a_mask,
  input  logic [63:0]            up_a_data,
  input  logic                   up_a_corrupt,
  output logic                   up_d_valid,
  input  logic                   up_d_ready,
  output logic [2:0]             up_d_opcode,
  output logic [1:0]             up_d_param,
  output logic [SIZE_W-1:0]      up_d_size,
  output logic [SOURCE_W-1:0]    up_d_source,
  output logic                   up_d_denied,
  output logic [63:0]            up_d_data,
  output logic                   down_a_valid,
  input  logic                   down_a_ready,
  output logic [2:0]             down_a_opcode,
  output logic [2:0]             down_a_param,
  output logic [SIZE_W-1:0]      down_a_size,
  output logic [SOURCE_W-1:0]    down_a_source,
  output logic [63:0]            down_a_address,
  output logic [7:0]             down_a_mask,
  output logic [63:0]            down_a_data,
  output logic                   down_a_corrupt,
  input  logic                   down_d_valid,
  output logic                   down_d_ready,
  input  logic [2:0]             down_d_opcode,
  input  logic [1:0]             down_d_param,
  input  logic [SIZE_W-1:0]      down_d_size,
  input  logic [SOURCE_W-1:0]    down_d_source,
  input  logic                   down_d_denied,
  input  logic [63:0]            down_d_data,
  output logic                   resv_valid,
  output logic [63-GRANULE_LSB:0] resv_addr,
  output logic [1:0]             fsm_state
);

  localparam int GW = 64 - GRANULE_LSB;
  // A timeout of 0 still needs a 1-bit timer; it is simply never loaded non-zero.
  localparam int TW = (RESV_TIMEOUT == 0) ? 1 : $clog2(RESV_TIMEOUT + 1);

  localparam logic [2:0] TL_PUT_F = 3'd0, TL_PUT_P = 3'd1, TL_ARITH_DATA = 3'd2,
                         TL_LOGIC_DATA = 3'd3, TL_GET = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK = 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_t;
  state_t state, state_nx;

  logic [2:0]          req_opcode, req_param;
  logic [SIZE_W-1:0]   req_size;
  logic [SOURCE_W-1:0] req_source;
  logic [63:0]         req_address, req_data;
  logic [7:0]          req_mask;
  logic                req_sc;

  logic [2:0]          rsp_opcode;
  logic [1:0]          rsp_param;
  logic [SIZE_W-1:0]   rsp_size;
  logic [SOURCE_W-1:0] rsp_source;
  logic                rsp_denied;
  logic [63:0]         rsp_data;

  logic [SOURCE_W-1:0] resv_source;
  logic [TW-1:0]       timer;

  // Request decode, meaningful while an A beat is offered in S_IDLE.
  logic          a_fire, is_lr, is_sc, sc_ok, is_put, is_write, write_hit;
  logic [GW-1:0] a_granule;

  assign a_fire    = (state == S_IDLE) && up_a_valid;
  assign a_granule = up_a_address[63:GRANULE_LSB];
  assign is_put    = (up_a_opcode == TL_PUT_F) || (up_a_opcode == TL_PUT_P);
  assign is_lr     = up_a_corrupt && (up_a_opcode == TL_GET);
  assign is_sc     = up_a_corrupt && is_put;
  assign sc_ok     = is_sc && resv_valid && (resv_addr == a_granule) &&
                     (resv_source == up_a_source);
  assign is_write  = (is_put && !up_a_corrupt) ||
                     (up_a_opcode == TL_ARITH_DATA) || (up_a_opcode == TL_LOGIC_DATA);
  assign write_hit = is_write && (resv_addr == a_granule);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    up_a_ready   = 1'b0;
    up_d_valid   = 1'b0;
    down_a_valid = 1'b0;
    down_d_ready = 1'b0;
    case (state)
      S_IDLE: begin
        up_a_ready   = 1'b1;
        // Also open in idle so a D beat left over from before a reset is drained.
        down_d_ready = 1'b1;
        if (up_a_valid) state_nx = (is_sc && !sc_ok) ? S_RSP : S_REQ;
      end
      S_REQ: begin
        down_a_valid = 1'b1;
        if (down_a_ready) state_nx = S_WAIT;
      end
      S_WAIT: begin
        down_d_ready = 1'b1;
        if (down_d_valid) state_nx = S_RSP;
      end
      S_RSP: begin
        up_d_valid = 1'b1;
        if (up_d_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_opcode  <= '0; req_param <= '0; req_size <= '0; req_source <= '0;
      req_address <= '0; req_mask  <= '0; req_data <= '0; req_sc     <= 1'b0;
      rsp_opcode  <= '0; rsp_param <= '0; rsp_size <= '0; rsp_source <= '0;
      rsp_denied  <= 1'b0; rsp_data <= '0;
    end else begin
      if (a_fire) begin
        req_opcode  <= up_a_opcode;
        req_param   <= up_a_param;
        req_size    <= up_a_size;
        req_source  <= up_a_source;
        req_address <= up_a_address;
        req_mask    <= up_a_mask;
        req_data    <= up_a_data;
        req_sc      <= sc_ok;
        if (is_sc && !sc_ok) begin
          rsp_opcode <= TL_ACCESS_ACK;
          rsp_param  <= '0;
          rsp_size   <= up_a_size;
          rsp_source <= up_a_source;
          rsp_denied <= 1'b0;
          rsp_data   <= 64'h1;
        end
      end
      if ((state == S_WAIT) && down_d_valid) begin
        rsp_opcode <= down_d_opcode;
        rsp_param  <= down_d_param;
        rsp_size   <= down_d_size;
        rsp_source <= down_d_source;
        rsp_denied <= down_d_denied;
        rsp_data   <= req_sc ? 64'h0 : down_d_data;
      end
    end
  end

  // Reservation. An LR accept wins over an expiry that falls in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resv_valid  <= 1'b0;
      resv_addr   <= '0;
      resv_source <= '0;
      timer       <= '0;
    end else if (a_fire && is_lr) begin
      resv_valid  <= 1'b1;
      resv_addr   <= a_granule;
      resv_source <= up_a_source;
      timer       <= TW'(RESV_TIMEOUT);
    end else if (a_fire && (is_sc || write_hit)) begin
      resv_valid <= 1'b0;
      timer      <= '0;
    end else if (resv_valid && (RESV_TIMEOUT != 0)) begin
      // The timer is at least 1 while live, so this stops at 0 and never wraps.
      timer <= timer - TW'(1);
      if (timer == TW'(1)) resv_valid <= 1'b0;
    end
  end

  assign down_a_opcode  = req_opcode;
  assign down_a_param   = req_param;
  assign down_a_size    = req_size;
  assign down_a_source  = req_source;
  assign down_a_address = req_address;
  assign down_a_mask    = req_mask;
  assign down_a_data    = req_data;
  assign down_a_corrupt = 1'b0;

  assign up_d_opcode = rsp_opcode;
  assign up_d_param  = rsp_param;
  assign up_d_size   = rsp_size;
  assign up_d_source = rsp_source;
  assign up_d_denied = rsp_denied;
  assign up_d_data   = rsp_data;

  assign fsm_state = state;

endmodule
